// File: rtl/smooth_pkg.sv
// Shared state encoding, default geometry and index clamping for the
// 3x3 smoothing window scheduler.
package smooth_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EMIT,
        S_DONE
    } state_t;

    localparam int DEF_IMG_W  = 128;
    localparam int DEF_IMG_H  = 128;
    localparam int DEF_PIX_W  = 8;
    localparam int DEF_ADDR_W = 14;

    // Out-of-range indices snap to the nearest edge so borders are replicated.
    function automatic int clamp_idx(input int idx, input int hi);
        if (idx < 0) begin
            return 0;
        end
        if (idx > hi) begin
            return hi;
        end
        return idx;
    endfunction

endpackage

// File: rtl/row_buffer_bank.sv
// Three rotating line buffers (row k lives in slot k mod 3) with a single
// write port and a combinational, edge-clamped 3x3 window read.
module row_buffer_bank
    import smooth_pkg::*;
#(
    parameter int  IMG_W = DEF_IMG_W,
    parameter int  IMG_H = DEF_IMG_H,
    parameter int  PIX_W = DEF_PIX_W,
    localparam int ROW_W = $clog2(IMG_H),
    localparam int COL_W = $clog2(IMG_W)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [1:0]            wr_slot,
    input  logic [COL_W-1:0]      wr_col,
    input  logic [PIX_W-1:0]      wr_data,
    input  logic [ROW_W-1:0]      rd_row,
    input  logic [COL_W-1:0]      rd_col,
    output logic [8:0][PIX_W-1:0] win
);

    logic [PIX_W-1:0] rows [3][IMG_W];
    int rr;
    int cc;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            rows[wr_slot][wr_col] <= wr_data;
        end
    end

    // Neighbour rows are found by clamping first, then mapping the row to its slot.
    always_comb begin
        rr  = 0;
        cc  = 0;
        win = '0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                rr = clamp_idx(int'(rd_row) + dr - 1, IMG_H - 1);
                cc = clamp_idx(int'(rd_col) + dc - 1, IMG_W - 1);
                win[4'(3 * dr + dc)] = rows[2'(rr % 3)][COL_W'(cc)];
            end
        end
    end

endmodule

// File: rtl/smooth_window_scheduler.sv
// Frame sequencer: fetches rows from frame memory into the row buffer bank and
// issues one 3x3 window per pixel in raster order over a valid/stall handshake.
module smooth_window_scheduler
    import smooth_pkg::*;
#(
    parameter int  IMG_W  = DEF_IMG_W,
    parameter int  IMG_H  = DEF_IMG_H,
    parameter int  PIX_W  = DEF_PIX_W,
    parameter int  ADDR_W = DEF_ADDR_W,
    localparam int ROW_W  = $clog2(IMG_H),
    localparam int COL_W  = $clog2(IMG_W)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_rd,
    input  logic [PIX_W-1:0]      mem_rdata,
    output logic [8:0][PIX_W-1:0] win,
    output logic                  win_valid,
    input  logic                  win_stall,
    output logic [ROW_W-1:0]      win_row,
    output logic [COL_W-1:0]      win_col
);

    // The column counter must reach IMG_W for the trailing write cycle of a fetch.
    localparam int CNT_W = $clog2(IMG_W + 1);

    state_t               state_q, state_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [CNT_W-1:0]     col_q, col_d;
    logic                 wr_en;
    logic [1:0]           wr_slot;
    logic [COL_W-1:0]     wr_col;
    logic [8:0][PIX_W-1:0] bank_win;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // row_q is the row being fetched in FETCH and the centre row in EMIT.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        busy      = 1'b0;
        done      = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        win_valid = 1'b0;
        wr_en     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_FETCH: begin
                busy = 1'b1;
                if (col_q < CNT_W'(IMG_W)) begin
                    mem_rd   = 1'b1;
                    mem_addr = ADDR_W'(row_q) * ADDR_W'(IMG_W) + ADDR_W'(col_q);
                end
                // Read data lags the address by one cycle, so writes trail by one column.
                wr_en = (col_q != '0);
                if (col_q == CNT_W'(IMG_W)) begin
                    col_d = '0;
                    if (row_q == '0) begin
                        row_d = ROW_W'(1);
                    end else begin
                        state_d = S_EMIT;
                        row_d   = row_q - ROW_W'(1);
                    end
                end else begin
                    col_d = col_q + CNT_W'(1);
                end
            end
            S_EMIT: begin
                busy      = 1'b1;
                win_valid = 1'b1;
                if (!win_stall) begin
                    if (col_q == CNT_W'(IMG_W - 1)) begin
                        col_d = '0;
                        if (int'(row_q) + 2 <= IMG_H - 1) begin
                            state_d = S_FETCH;
                            row_d   = row_q + ROW_W'(2);
                        end else if (int'(row_q) + 1 <= IMG_H - 1) begin
                            row_d = row_q + ROW_W'(1);
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        col_d = col_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
                row_d   = '0;
                col_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign wr_slot = 2'(int'(row_q) % 3);
    assign wr_col  = COL_W'(col_q - CNT_W'(1));

    // Window outputs are forced to zero whenever no window is being presented.
    assign win     = win_valid ? bank_win : '0;
    assign win_row = win_valid ? row_q : '0;
    assign win_col = win_valid ? COL_W'(col_q) : '0;

    row_buffer_bank #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .PIX_W(PIX_W)
    ) u_bank (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_slot(wr_slot),
        .wr_col (wr_col),
        .wr_data(mem_rdata),
        .rd_row (row_q),
        .rd_col (COL_W'(col_q)),
        .win    (bank_win)
    );

endmodule

// File: tb/tb_smooth_window_scheduler.sv
// Bench for smooth_window_scheduler: a 4x4 instance for directed scenarios and
// a 128x128 instance under random backpressure, both checked by scoreboards.
module tb_smooth_window_scheduler;

    typedef struct packed {
        logic [6:0]  r;
        logic [6:0]  c;
        logic [71:0] w;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic            start_s, busy_s, done_s, mem_rd_s, win_valid_s, win_stall_s;
    logic [3:0]      mem_addr_s;
    logic [7:0]      mem_rdata_s;
    logic [8:0][7:0] win_s;
    logic [1:0]      win_row_s, win_col_s;

    logic            start_b, busy_b, done_b, mem_rd_b, win_valid_b, win_stall_b;
    logic [13:0]     mem_addr_b;
    logic [7:0]      mem_rdata_b;
    logic [8:0][7:0] win_b;
    logic [6:0]      win_row_b, win_col_b;

    int n_checks = 0;
    int n_fail   = 0;
    int xfer_s, reads_s, done_cnt_s, mem_exp_s, rd_addr_s;
    int xfer_b, reads_b, done_cnt_b, mem_exp_b, rd_addr_b;
    bit rd_pend_s = 1'b0;
    bit rd_pend_b = 1'b0;
    exp_t sb_s[$];
    exp_t sb_b[$];

    int w00[9] = '{0, 0, 1, 0, 0, 1, 4, 4, 5};
    int w33[9] = '{10, 11, 11, 14, 15, 15, 14, 15, 15};
    int w12[9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    int w13[9] = '{2, 3, 3, 6, 7, 7, 10, 11, 11};

    smooth_window_scheduler #(.IMG_W(4), .IMG_H(4), .PIX_W(8), .ADDR_W(4)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .busy(busy_s), .done(done_s),
        .mem_addr(mem_addr_s), .mem_rd(mem_rd_s), .mem_rdata(mem_rdata_s),
        .win(win_s), .win_valid(win_valid_s), .win_stall(win_stall_s),
        .win_row(win_row_s), .win_col(win_col_s)
    );

    smooth_window_scheduler #(.IMG_W(128), .IMG_H(128), .PIX_W(8), .ADDR_W(14)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .mem_rdata(mem_rdata_b),
        .win(win_b), .win_valid(win_valid_b), .win_stall(win_stall_b),
        .win_row(win_row_b), .win_col(win_col_b)
    );

    function automatic int clampI(input int x, input int hi);
        return (x < 0) ? 0 : ((x > hi) ? hi : x);
    endfunction

    function automatic logic [7:0] pix(input int r, input int c, input bit big);
        return big ? 8'((r * 7 + c * 13 + (r ^ c)) & 255) : 8'(4 * r + c);
    endfunction

    function automatic logic [71:0] expWin(input int r, input int c, input int w, input int h, input bit big);
        logic [71:0] v;
        v = '0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                v[8 * (3 * dr + dc) +: 8] = pix(clampI(r + dr - 1, h - 1), clampI(c + dc - 1, w - 1), big);
            end
        end
        return v;
    endfunction

    function automatic logic [71:0] packList(input int a[9]);
        logic [71:0] v;
        v = '0;
        for (int k = 0; k < 9; k++) begin
            v[8 * k +: 8] = 8'(a[k]);
        end
        return v;
    endfunction

    function automatic logic [127:0] allOutS();
        return {busy_s, done_s, mem_addr_s, mem_rd_s, win_s, win_valid_s, win_row_s, win_col_s};
    endfunction

    function automatic logic [127:0] allOutB();
        return {busy_b, done_b, mem_addr_b, mem_rd_b, win_b, win_valid_b, win_row_b, win_col_b};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Loads the scoreboard with the whole frame, then pulses start.
    task automatic applyStimulus(input bit big);
        if (!big) begin
            sb_s.delete();
            xfer_s = 0; reads_s = 0; done_cnt_s = 0; mem_exp_s = 0;
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    sb_s.push_back(exp_t'({7'(r), 7'(c), expWin(r, c, 4, 4, 1'b0)}));
            start_s = 1'b1;
        end else begin
            sb_b.delete();
            xfer_b = 0; reads_b = 0; done_cnt_b = 0; mem_exp_b = 0;
            for (int r = 0; r < 128; r++)
                for (int c = 0; c < 128; c++)
                    sb_b.push_back(exp_t'({7'(r), 7'(c), expWin(r, c, 128, 128, 1'b1)}));
            start_b = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            rd_pend_s = 1'b0;
        end else begin
            rd_pend_s = mem_rd_s;
            rd_addr_s = int'(mem_addr_s);
            if (mem_rd_s) begin
                checkOutput("mem_trace_s", {win_valid_s, mem_addr_s}, {1'b0, 4'(mem_exp_s)});
                mem_exp_s++;
                reads_s++;
            end
            if (win_valid_s && !win_stall_s) begin
                checkOutput("sb_nonempty_s", sb_s.size() > 0, 1'b1);
                if (sb_s.size() > 0) begin
                    exp_t e;
                    e = sb_s.pop_front();
                    checkOutput("window_s", {win_row_s, win_col_s, win_s}, {e.r[1:0], e.c[1:0], e.w});
                end
                if (win_row_s == 2'd0 && win_col_s == 2'd0) checkOutput("window_0_0", win_s, packList(w00));
                if (win_row_s == 2'd3 && win_col_s == 2'd3) checkOutput("window_3_3", win_s, packList(w33));
                xfer_s++;
            end
            if (done_s) done_cnt_s++;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            rd_pend_b = 1'b0;
        end else begin
            rd_pend_b = mem_rd_b;
            rd_addr_b = int'(mem_addr_b);
            if (mem_rd_b) begin
                checkOutput("mem_trace_b", {win_valid_b, mem_addr_b}, {1'b0, 14'(mem_exp_b)});
                mem_exp_b++;
                reads_b++;
            end
            if (win_valid_b && !win_stall_b) begin
                checkOutput("sb_nonempty_b", sb_b.size() > 0, 1'b1);
                if (sb_b.size() > 0) begin
                    exp_t e;
                    e = sb_b.pop_front();
                    checkOutput("window_b", {win_row_b, win_col_b, win_b}, {e.r, e.c, e.w});
                end
                xfer_b++;
            end
            if (done_b) done_cnt_b++;
        end
    end

    // Frame memory models: a read issued in one cycle returns data in the next.
    always @(posedge clk) begin
        #1;
        mem_rdata_s = rd_pend_s ? pix(rd_addr_s / 4, rd_addr_s % 4, 1'b0) : 8'hxx;
        mem_rdata_b = rd_pend_b ? pix(rd_addr_b / 128, rd_addr_b % 128, 1'b1) : 8'hxx;
    end

    task automatic runSmall(input int srow, input int scol, input int slen, input logic [71:0] hold_w,
                            input int extra_start, output int cyc);
        bit found;
        int left;
        found = 1'b0;
        left  = 0;
        cyc   = 0;
        applyStimulus(1'b0);
        while (cyc < 500) begin
            @(posedge clk); #1;
            start_s = 1'b0;
            cyc++;
            if (cyc == extra_start) start_s = 1'b1;
            if (left > 0) begin
                left--;
                if (left == 0) win_stall_s = 1'b0;
            end
            if (!found && slen > 0 && win_valid_s && int'(win_row_s) == srow && int'(win_col_s) == scol) begin
                found       = 1'b1;
                win_stall_s = 1'b1;
                left        = slen;
            end
            if (win_stall_s)
                checkOutput("stall_hold", {win_valid_s, win_row_s, win_col_s, win_s},
                            {1'b1, 2'(srow), 2'(scol), hold_w});
            if (done_s) break;
        end
        win_stall_s = 1'b0;
        if (slen > 0) checkOutput("stall_target_seen", found, 1'b1);
        checkOutput("done_seen_s", done_s, 1'b1);
        checkOutput("busy_low_at_done", busy_s, 1'b0);
    endtask

    // Latency is counted inclusively from the start cycle to the done cycle.
    task automatic finishFrameS(input string tag, input int exp_lat, input int cyc);
        checkOutput({tag, "_latency"}, cyc + 1, exp_lat);
        @(posedge clk); #1;
        checkOutput({tag, "_done_single"}, {done_s, busy_s}, 2'b00);
        checkOutput({tag, "_transfers"}, xfer_s, 16);
        checkOutput({tag, "_reads"}, reads_s, 16);
        checkOutput({tag, "_sb_empty"}, sb_s.size(), 0);
        checkOutput({tag, "_done_count"}, done_cnt_s, 1);
    endtask

    initial begin
        int n;
        reset       = 1'b1;
        start_s     = 1'b0;
        start_b     = 1'b0;
        win_stall_s = 1'b0;
        win_stall_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state_s", allOutS(), '0);
        checkOutput("reset_state_b", allOutB(), '0);
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle_after_release", {win_valid_s, mem_rd_s, busy_s}, 3'b000);

        $display("[TB] 4x4 frame, no stall");
        runSmall(-1, -1, 0, '0, -1, n);
        finishFrameS("plain", 38, n);

        $display("[TB] 4x4 frame, 3-cycle stall on window (1,2)");
        runSmall(1, 2, 3, packList(w12), -1, n);
        finishFrameS("stall_1_2", 41, n);

        $display("[TB] 4x4 frame, 3-cycle stall on window (1,3)");
        runSmall(1, 3, 3, packList(w13), -1, n);
        finishFrameS("stall_1_3", 41, n);

        $display("[TB] 4x4 frame, start pulsed while busy");
        runSmall(-1, -1, 0, '0, 10, n);
        finishFrameS("restart_ignored", 38, n);

        $display("[TB] 4x4 frame, reset mid-frame");
        applyStimulus(1'b0);
        repeat (20) begin
            @(posedge clk); #1;
            start_s = 1'b0;
        end
        checkOutput("busy_before_reset", busy_s, 1'b1);
        #2 reset = 1'b1;
        #1 checkOutput("async_reset_outputs", allOutS(), '0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("quiet_after_release", {win_valid_s, mem_rd_s, busy_s}, 3'b000);
        runSmall(-1, -1, 0, '0, -1, n);
        finishFrameS("after_reset", 38, n);

        $display("[TB] 128x128 frame, random 30%% stall");
        applyStimulus(1'b1);
        n = 0;
        while (n < 60000) begin
            @(posedge clk); #1;
            start_b = 1'b0;
            n++;
            if (done_b) break;
            win_stall_b = ($urandom_range(0, 99) < 30);
        end
        win_stall_b = 1'b0;
        checkOutput("big_done_seen", done_b, 1'b1);
        @(posedge clk); #1;
        checkOutput("big_transfers", xfer_b, 16384);
        checkOutput("big_reads", reads_b, 16384);
        checkOutput("big_sb_empty", sb_b.size(), 0);
        checkOutput("big_done_count", done_cnt_b, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
